// File: rtl/avalon_irq_pkg.sv
// Shared constants and helpers for the Avalon-MM interrupt controller.
package avalon_irq_pkg;

    localparam int unsigned ADDR_W       = 3;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ID_IDX_W     = 5;
    localparam int unsigned ID_VALID_BIT = 31;

    localparam logic [ADDR_W-1:0] ADDR_PENDING  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_ID       = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd5;

    // Pack the winning-source word: valid flag on top, index in the low bits.
    function automatic logic [DATA_W-1:0] make_id(input logic valid, input logic [ID_IDX_W-1:0] idx);
        logic [DATA_W-1:0] word;
        word                  = '0;
        word[ID_VALID_BIT]    = valid;
        word[ID_IDX_W-1:0]    = idx;
        return word;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active interrupt vector.
module irq_prio_enc
    import avalon_irq_pkg::*;
#(
    parameter int unsigned N_SRC = 8
) (
    input  logic [N_SRC-1:0]    req,
    output logic                valid_c,
    output logic [ID_IDX_W-1:0] idx_c
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid_c = 1'b1;
                idx_c   = ID_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/avalon_irq_ctrl.sv
// Avalon-MM interrupt controller: synchronises, latches, masks and prioritises
// N_SRC request lines into one registered irq for the core.
module avalon_irq_ctrl
    import avalon_irq_pkg::*;
#(
    parameter int unsigned N_SRC       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    input  logic [N_SRC-1:0]  src,
    output logic              irq
);

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] edge_sel;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] wdata;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] rise;
    logic             wr_acc;
    logic             rd_acc;
    logic             id_valid;
    logic [ID_IDX_W-1:0] id_idx;
    logic [DATA_W-1:0]   rd_mux;
    logic                unused_wdata;

    assign s            = sync_q[SYNC_STAGES-1];
    assign wr_acc       = chipselect & write;
    assign rd_acc       = chipselect & read;
    assign wdata        = writedata[N_SRC-1:0];
    assign unused_wdata = ^writedata[DATA_W-1:N_SRC];
    assign active       = pending & enable;

    // Per-source synchroniser chain plus edge-history flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= src;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            prev <= s;
        end
    end

    // Edge sources latch and only clear by W1C (set wins); level sources follow s.
    always_comb begin
        w1c          = '0;
        rise         = s & ~prev;
        if (wr_acc && (address == ADDR_PENDING)) w1c = wdata;
        pending_next = (edge_sel & ((pending & ~w1c) | rise)) | (~edge_sel & s);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending  <= '0;
            enable   <= '0;
            edge_sel <= '0;
        end else begin
            pending <= pending_next;
            if (wr_acc && (address == ADDR_ENABLE))   enable   <= wdata;
            if (wr_acc && (address == ADDR_EDGE_SEL)) edge_sel <= wdata;
        end
    end

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req     (active),
        .valid_c (id_valid),
        .idx_c   (id_idx)
    );

    // Read mux sees pre-write state, so a same-edge write never leaks into readdata.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_PENDING:  rd_mux = DATA_W'(pending);
            ADDR_ENABLE:   rd_mux = DATA_W'(enable);
            ADDR_EDGE_SEL: rd_mux = DATA_W'(edge_sel);
            ADDR_ACTIVE:   rd_mux = DATA_W'(active);
            ADDR_ID:       rd_mux = make_id(id_valid, id_idx);
            ADDR_RAW:      rd_mux = DATA_W'(s);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (rd_acc) readdata <= rd_mux;
            irq <= |active;
        end
    end

endmodule
